// File: rtl/pipe_pkg.sv
// Shared widths and state encoding for the pipeline stage register.
package pipe_pkg;

  localparam int PIPE_CTRL_W = 11;
  localparam int PIPE_DATA_W = 8;
  localparam int PIPE_LANES  = 6;
  localparam int PIPE_CNT_W  = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2,
    FULL  = 2'd3
  } stage_state_e;

endpackage

// File: rtl/pipe_skid_entry.sv
// One held word of the stage: valid bit plus ctrl/data, loaded or cleared.
module pipe_skid_entry #(
  parameter int CTRL_W = 11,
  parameter int DW     = 48
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] next_ctrl,
  input  logic [DW-1:0]     next_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DW-1:0]     data
);

  // clear drops only the valid bit; data lanes keep their last value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= next_ctrl;
      data  <= next_data;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush and stall counter.
// Define PIPE_STAGE_SKID_EN for a two-entry skid buffer with registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int DATA_W = PIPE_DATA_W,
  parameter int LANES  = PIPE_LANES,
  parameter int CNT_W  = PIPE_CNT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CTRL_W-1:0]       in_ctrl,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CTRL_W-1:0]       out_ctrl,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]        stall_cnt
);

  localparam int DW = LANES * DATA_W;

  stage_state_e      state, state_n;
  logic              main_v, main_load, main_clear;
  logic [CTRL_W-1:0] main_ctrl, main_next_ctrl;
  logic [DW-1:0]     main_data, main_next_data;
  logic              accept, xfer;

  assign accept    = in_valid & in_ready;
  assign xfer      = out_valid & out_ready;
  assign out_valid = main_v;
  assign out_ctrl  = main_v ? main_ctrl : '0;
  assign out_data  = main_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_n;
  end

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_v, skid_load, skid_clear;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DW-1:0]     skid_data;
  logic              ready_q;

  assign in_ready       = ready_q;
  assign main_next_ctrl = skid_v ? skid_ctrl : in_ctrl;
  assign main_next_data = skid_v ? skid_data : in_data;

  always_comb begin
    state_n    = state;
    main_load  = 1'b0;
    main_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (flush) begin
      state_n    = EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      unique case (state)
        EMPTY: if (accept) begin
          state_n   = ONE;
          main_load = 1'b1;
        end
        ONE: if (accept && xfer) begin
          main_load = 1'b1;
        end else if (accept) begin
          state_n   = TWO;
          skid_load = 1'b1;
        end else if (xfer) begin
          state_n    = EMPTY;
          main_clear = 1'b1;
        end
        TWO: if (xfer) begin
          state_n    = ONE;
          main_load  = 1'b1;
          skid_clear = 1'b1;
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  // registered ready breaks the out_ready -> in_ready path
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ready_q <= 1'b0;
    else       ready_q <= (state_n != TWO);
  end

  pipe_skid_entry #(
    .CTRL_W (CTRL_W),
    .DW     (DW)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .load      (skid_load),
    .clear     (skid_clear),
    .next_ctrl (in_ctrl),
    .next_data (in_data),
    .valid     (skid_v),
    .ctrl      (skid_ctrl),
    .data      (skid_data)
  );
`else
  logic live;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) live <= 1'b0;
    else       live <= 1'b1;
  end

  assign in_ready       = live & ((state != FULL) | out_ready);
  assign main_next_ctrl = in_ctrl;
  assign main_next_data = in_data;

  always_comb begin
    state_n    = state;
    main_load  = 1'b0;
    main_clear = 1'b0;
    if (flush) begin
      state_n    = EMPTY;
      main_clear = 1'b1;
    end else begin
      unique case (state)
        EMPTY: if (accept) begin
          state_n   = FULL;
          main_load = 1'b1;
        end
        FULL: if (accept) begin
          main_load = 1'b1;
        end else if (xfer) begin
          state_n    = EMPTY;
          main_clear = 1'b1;
        end
        default: state_n = EMPTY;
      endcase
    end
  end
`endif

  pipe_skid_entry #(
    .CTRL_W (CTRL_W),
    .DW     (DW)
  ) u_main (
    .clk       (clk),
    .reset     (reset),
    .load      (main_load),
    .clear     (main_clear),
    .next_ctrl (main_next_ctrl),
    .next_data (main_next_data),
    .valid     (main_v),
    .ctrl      (main_ctrl),
    .data      (main_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && !(&stall_cnt))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter CTRL_W, default 11, width of the control bundle (write enables, selects, branch/ret flags).
REQ-002 Parameter DATA_W, default 8, width of one data lane.
REQ-003 Parameter LANES, default 6, number of data lanes (ALU result, store data, address, port, etc.).
REQ-004 Parameter CNT_W, default 16, width of the stall counter.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  upstream stage holds a valid instruction.
REQ-008 in_ready  output  1  this stage accepts in_ctrl/in_data this cycle.
REQ-009 in_ctrl  input  CTRL_W  upstream control bundle.
REQ-010 in_data  input  LANES*DATA_W  upstream data lanes, lane 0 in the LSBs.
REQ-011 flush  input  1  synchronous kill of all held and incoming instructions.
REQ-012 out_valid  output  1  downstream copy is valid.
REQ-013 out_ready  input  1  downstream stage consumes the output this cycle.
REQ-014 out_ctrl  output  CTRL_W  registered control bundle, gated by out_valid.
REQ-015 out_data  output  LANES*DATA_W  registered data lanes.
REQ-016 stall_cnt  output  CNT_W  count of cycles with out_valid=1 and out_ready=0.

Function
REQ-017 Transfer in: in_valid and in_ready high on one rising edge; transfer out: out_valid and out_ready high on one rising edge.
REQ-018 Latency: an accepted word SHALL appear on out_* on the cycle after acceptance when the stage was empty.
REQ-019 Ordering: words SHALL leave in acceptance order; no word is duplicated or dropped except by flush.
REQ-020 out_ctrl SHALL equal zero whenever out_valid=0, so bubbles never assert write enables.
REQ-021 out_data SHALL hold its last value while out_valid=0 (no clearing of data lanes).
REQ-022 Held outputs SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 flush SHALL, on the next edge, clear every held entry and discard any word presented that cycle; out_valid=0 the following cycle.
REQ-024 flush takes priority over simultaneous in/out transfers; the downstream transfer in the flush cycle still completes.
REQ-025 stall_cnt SHALL increment by 1 on each edge with out_valid=1 and out_ready=0 and saturate at all-ones (no wrap).
REQ-026 stall_cnt SHALL not be cleared by flush.

Reset
REQ-027 reset high SHALL immediately force out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, all entries empty.
REQ-028 in_ready SHALL be 0 while reset is high and 1 from the first edge after reset release.
REQ-029 Reset asserted mid-transfer SHALL discard all held words; no partial word emerges.

Configuration
REQ-030 Macro PIPE_STAGE_SKID_EN defined: two entries (main, skid), states EMPTY, ONE, TWO; in_ready is registered, equal to "not TWO".
REQ-031 With skid: EMPTY->ONE on accept; ONE->TWO on accept without out transfer; ONE->EMPTY on out transfer without accept; TWO->ONE on out transfer (skid moves to main); ONE stays ONE on simultaneous accept and out transfer; any state->EMPTY on flush.
REQ-032 With skid, full throughput (one word per cycle) SHALL be sustained with in_ready having no combinational path from out_ready.
REQ-033 Macro undefined: single entry, states EMPTY, FULL; in_ready = not FULL or out_ready (combinational); simultaneous accept and out transfer in FULL stays FULL with the new word.

Structure
REQ-034 Package pipe_pkg SHALL hold default CTRL_W/DATA_W/LANES/CNT_W constants and the state encoding typedef (EMPTY, ONE, TWO/FULL).
REQ-035 One sub-module pipe_skid_entry (one valid bit + ctrl + data register with load/clear) SHALL be instantiated once or twice.

Verification
REQ-036 Reset: reset=1 mid-stream with out_valid=1 -> out_valid=0, out_ctrl=0, stall_cnt=0 immediately; in_ready=1 one edge after release.
REQ-037 Streaming: in_valid=1 with lane0 = 0x01..0x10 every cycle, out_ready=1 -> outputs 0x01..0x10 in order, one per cycle, first one cycle after first accept.
REQ-038 Backpressure (skid on): stream 0xA0,0xA1,0xA2, out_ready=0 from cycle 1 -> in_ready=0 after two accepts, out holds 0xA0, stall_cnt counts 1,2,3; out_ready=1 -> 0xA0,0xA1,0xA2 with none lost.
REQ-039 Flush: two words held, flush=1 with in_valid=1 lane0=0x55 -> next cycle out_valid=0, out_ctrl=0, 0x55 never emerges, stall_cnt unchanged.
REQ-040 Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays 15.
REQ-041 Bubble gating: in_ctrl=all-ones with in_valid=0 -> out_ctrl remains 0 and out_valid remains 0.
